// File: rtl/sat_ctrl_seq.sv
// Sequencing controller for a bin-level SAT engine: imply/decide/analyze/backtrack
// loop with decision budget, per-phase watchdog and saturating statistics.
module sat_ctrl_seq #(
    parameter int WIDTH_LVL  = 16,
    parameter int WIDTH_BIN  = 10,
    parameter int WIDTH_CNT  = 16,
    parameter int WIDTH_WDOG = 12,
    parameter int WDOG_LIMIT = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_core_i,
    input  logic [WIDTH_BIN-1:0] cur_bin_num_i,
    input  logic [WIDTH_CNT-1:0] budget_i,
    output logic                 done_core_o,
    output logic                 sat_o,
    output logic                 unsat_o,
    output logic                 global_unsat_o,
    output logic                 abort_o,
    output logic                 wdog_err_o,
    output logic [WIDTH_BIN-1:0] bkt_bin_o,
    output logic [WIDTH_LVL-1:0] bkt_lvl_o,
    output logic                 apply_imply_o,
    input  logic                 done_imply_i,
    input  logic                 conflict_i,
    output logic                 start_decision_o,
    input  logic                 done_decision_i,
    input  logic                 all_c_is_sat_i,
    output logic                 apply_analyze_o,
    input  logic                 done_analyze_i,
    input  logic [WIDTH_BIN-1:0] bkt_bin_num_i,
    input  logic [WIDTH_LVL-1:0] bkt_lvl_i,
    output logic                 apply_bkt_cur_bin_o,
    input  logic                 done_bkt_cur_bin_i,
    output logic [WIDTH_CNT-1:0] conflicts_o,
    output logic [WIDTH_CNT-1:0] decisions_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {IDLE, IMPLY, DECIDE, ANALYZE, BKT, DONE} state_t;

    localparam logic [WIDTH_WDOG-1:0] WDOG_LAST = WIDTH_WDOG'(WDOG_LIMIT - 1);

    state_t                state, state_nxt;
    logic [WIDTH_BIN-1:0]  lat_bin;
    logic [WIDTH_CNT-1:0]  lat_budget;
    logic [WIDTH_WDOG-1:0] wdog;
    logic                  phase_done;
    logic                  wdog_hit;
    logic                  budget_hit;
    logic [WIDTH_CNT-1:0]  dec_next;
    logic [WIDTH_CNT-1:0]  conf_next;

    function automatic logic [WIDTH_CNT-1:0] sat_inc(input logic [WIDTH_CNT-1:0] v);
        return (&v) ? v : v + WIDTH_CNT'(1);
    endfunction

    always_comb begin
        phase_done = 1'b0;
        case (state)
            IMPLY:   phase_done = done_imply_i;
            DECIDE:  phase_done = done_decision_i;
            ANALYZE: phase_done = done_analyze_i;
            BKT:     phase_done = done_bkt_cur_bin_i;
            default: phase_done = 1'b0;
        endcase
        wdog_hit   = (state != IDLE) && (state != DONE) && (wdog == WDOG_LAST) && !phase_done;
        dec_next   = sat_inc(decisions_o);
        conf_next  = sat_inc(conflicts_o);
        budget_hit = (lat_budget != '0) && (dec_next >= lat_budget);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_core_i) state_nxt = IMPLY;
            IMPLY:   if (done_imply_i) state_nxt = conflict_i ? ANALYZE : DECIDE;
            DECIDE:  if (done_decision_i)
                         state_nxt = (all_c_is_sat_i || budget_hit) ? DONE : IMPLY;
            ANALYZE: if (done_analyze_i)
                         state_nxt = (bkt_bin_num_i != '0 && bkt_bin_num_i == lat_bin) ? BKT : DONE;
            BKT:     if (done_bkt_cur_bin_i) state_nxt = IMPLY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (wdog_hit) state_nxt = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            lat_bin             <= '0;
            lat_budget          <= '0;
            wdog                <= '0;
            done_core_o         <= 1'b0;
            sat_o               <= 1'b0;
            unsat_o             <= 1'b0;
            global_unsat_o      <= 1'b0;
            abort_o             <= 1'b0;
            wdog_err_o          <= 1'b0;
            bkt_bin_o           <= '0;
            bkt_lvl_o           <= '0;
            apply_imply_o       <= 1'b0;
            start_decision_o    <= 1'b0;
            apply_analyze_o     <= 1'b0;
            apply_bkt_cur_bin_o <= 1'b0;
            conflicts_o         <= '0;
            decisions_o         <= '0;
            busy_o              <= 1'b0;
        end else begin
            state <= state_nxt;
            // Moore outputs are registered from the next state so they align with it.
            apply_imply_o       <= (state_nxt == IMPLY);
            start_decision_o    <= (state_nxt == DECIDE);
            apply_analyze_o     <= (state_nxt == ANALYZE);
            apply_bkt_cur_bin_o <= (state_nxt == BKT);
            done_core_o         <= (state_nxt == DONE);
            busy_o              <= (state_nxt != IDLE);

            if (state == IDLE || state_nxt != state) wdog <= '0;
            else                                     wdog <= wdog + WIDTH_WDOG'(1);

            case (state)
                IDLE: if (start_core_i) begin
                    lat_bin        <= cur_bin_num_i;
                    lat_budget     <= budget_i;
                    conflicts_o    <= '0;
                    decisions_o    <= '0;
                    sat_o          <= 1'b0;
                    unsat_o        <= 1'b0;
                    global_unsat_o <= 1'b0;
                    abort_o        <= 1'b0;
                    wdog_err_o     <= 1'b0;
                end
                IMPLY: if (done_imply_i && conflict_i) conflicts_o <= conf_next;
                DECIDE: if (done_decision_i) begin
                    if (all_c_is_sat_i) begin
                        sat_o <= 1'b1;
                    end else begin
                        decisions_o <= dec_next;
                        if (budget_hit) abort_o <= 1'b1;
                    end
                end
                ANALYZE: if (done_analyze_i && bkt_bin_num_i != lat_bin) begin
                    unsat_o   <= 1'b1;
                    bkt_bin_o <= bkt_bin_num_i;
                    bkt_lvl_o <= bkt_lvl_i;
                    if (bkt_bin_num_i == '0) global_unsat_o <= 1'b1;
                end
                default: ;
            endcase

            if (wdog_hit) begin
                abort_o    <= 1'b1;
                wdog_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sat_ctrl_seq.sv
// Scoreboard bench for sat_ctrl_seq: stimulus pushes expected results,
// a monitor pops and compares them on every done_core_o pulse.
module tb_sat_ctrl_seq;

    localparam int WL   = 16;
    localparam int WB   = 10;
    localparam int WC   = 4;
    localparam int WW   = 12;
    localparam int WLIM = 8;

    logic          clk, rst;
    logic          start_core_i;
    logic [WB-1:0] cur_bin_num_i;
    logic [WC-1:0] budget_i;
    logic          done_core_o, sat_o, unsat_o, global_unsat_o, abort_o, wdog_err_o;
    logic [WB-1:0] bkt_bin_o;
    logic [WL-1:0] bkt_lvl_o;
    logic          apply_imply_o, done_imply_i, conflict_i;
    logic          start_decision_o, done_decision_i, all_c_is_sat_i;
    logic          apply_analyze_o, done_analyze_i;
    logic [WB-1:0] bkt_bin_num_i;
    logic [WL-1:0] bkt_lvl_i;
    logic          apply_bkt_cur_bin_o, done_bkt_cur_bin_i;
    logic [WC-1:0] conflicts_o, decisions_o;
    logic          busy_o;

    sat_ctrl_seq #(
        .WIDTH_LVL (WL),
        .WIDTH_BIN (WB),
        .WIDTH_CNT (WC),
        .WIDTH_WDOG(WW),
        .WDOG_LIMIT(WLIM)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start_core_i       (start_core_i),
        .cur_bin_num_i      (cur_bin_num_i),
        .budget_i           (budget_i),
        .done_core_o        (done_core_o),
        .sat_o              (sat_o),
        .unsat_o            (unsat_o),
        .global_unsat_o     (global_unsat_o),
        .abort_o            (abort_o),
        .wdog_err_o         (wdog_err_o),
        .bkt_bin_o          (bkt_bin_o),
        .bkt_lvl_o          (bkt_lvl_o),
        .apply_imply_o      (apply_imply_o),
        .done_imply_i       (done_imply_i),
        .conflict_i         (conflict_i),
        .start_decision_o   (start_decision_o),
        .done_decision_i    (done_decision_i),
        .all_c_is_sat_i     (all_c_is_sat_i),
        .apply_analyze_o    (apply_analyze_o),
        .done_analyze_i     (done_analyze_i),
        .bkt_bin_num_i      (bkt_bin_num_i),
        .bkt_lvl_i          (bkt_lvl_i),
        .apply_bkt_cur_bin_o(apply_bkt_cur_bin_o),
        .done_bkt_cur_bin_i (done_bkt_cur_bin_i),
        .conflicts_o        (conflicts_o),
        .decisions_o        (decisions_o),
        .busy_o             (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {sat, unsat, global_unsat, abort, wdog_err}
    typedef struct {
        logic [4:0]    flags;
        logic          chk_bkt;
        logic [WB-1:0] bin;
        logic [WL-1:0] lvl;
        logic [WC-1:0] conf;
        logic [WC-1:0] dec;
    } exp_t;

    localparam int R_IMPLY = 0, R_DECIDE = 1, R_ANALYZE = 2, R_BKT = 3, R_DONE = 4;

    exp_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    string nm[5] = '{"imply", "decide", "analyze", "bkt", "done_core"};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [4:0] flags, input logic chk_bkt, input logic [WB-1:0] bin,
                            input logic [WL-1:0] lvl, input logic [WC-1:0] conf, input logic [WC-1:0] dec);
        exp_t e;
        e.flags = flags; e.chk_bkt = chk_bkt; e.bin = bin; e.lvl = lvl; e.conf = conf; e.dec = dec;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done_core_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done_core", 1, 0);
            end else begin
                e = sb.pop_front();
                check("result_flags", {sat_o, unsat_o, global_unsat_o, abort_o, wdog_err_o}, e.flags);
                check("conflicts_o", conflicts_o, e.conf);
                check("decisions_o", decisions_o, e.dec);
                if (e.chk_bkt) begin
                    check("bkt_bin_o", bkt_bin_o, e.bin);
                    check("bkt_lvl_o", bkt_lvl_o, e.lvl);
                end
            end
        end
    end

    function automatic logic req(input int r);
        case (r)
            R_IMPLY:   return apply_imply_o;
            R_DECIDE:  return start_decision_o;
            R_ANALYZE: return apply_analyze_o;
            R_BKT:     return apply_bkt_cur_bin_o;
            default:   return done_core_o;
        endcase
    endfunction

    function automatic logic [63:0] all_outs();
        return {done_core_o, sat_o, unsat_o, global_unsat_o, abort_o, wdog_err_o, bkt_bin_o, bkt_lvl_o,
                apply_imply_o, start_decision_o, apply_analyze_o, apply_bkt_cur_bin_o,
                conflicts_o, decisions_o, busy_o};
    endfunction

    // Called at a negedge with request r high; qualifiers are preset by the caller.
    task automatic pulse(input int r, input int nxt);
        check({"req_", nm[r], "_before"}, req(r), 1);
        case (r)
            R_IMPLY:   done_imply_i = 1'b1;
            R_DECIDE:  done_decision_i = 1'b1;
            R_ANALYZE: done_analyze_i = 1'b1;
            default:   done_bkt_cur_bin_i = 1'b1;
        endcase
        @(negedge clk);
        done_imply_i = 1'b0; done_decision_i = 1'b0; done_analyze_i = 1'b0; done_bkt_cur_bin_i = 1'b0;
        conflict_i = 1'b0; all_c_is_sat_i = 1'b0;
        check({"req_", nm[r], "_dropped"}, req(r), 0);
        check({"req_", nm[nxt], "_raised"}, req(nxt), 1);
    endtask

    task automatic start_solve(input logic [WB-1:0] bin, input logic [WC-1:0] bud);
        cur_bin_num_i = bin; budget_i = bud; start_core_i = 1'b1;
        @(negedge clk);
        start_core_i = 1'b0;
        check("start_imply_req", apply_imply_o, 1);
        check("start_busy", busy_o, 1);
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("done_core_single_pulse", done_core_o, 0);
        check("idle_not_busy", busy_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_core_i = 1'b0; cur_bin_num_i = '0; budget_i = '0;
        done_imply_i = 1'b0; conflict_i = 1'b0; done_decision_i = 1'b0; all_c_is_sat_i = 1'b0;
        done_analyze_i = 1'b0; bkt_bin_num_i = '0; bkt_lvl_i = '0; done_bkt_cur_bin_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);

        // Trivially SAT
        push_exp(5'b10000, 1'b0, '0, '0, 4'd0, 4'd0);
        start_solve(10'd1, 4'd0);
        pulse(R_IMPLY, R_DECIDE);
        all_c_is_sat_i = 1'b1;
        pulse(R_DECIDE, R_DONE);
        idle_check();

        // In-bin conflict, with a start pulse while busy that must be ignored
        push_exp(5'b10000, 1'b0, '0, '0, 4'd1, 4'd0);
        start_solve(10'd5, 4'd0);
        conflict_i = 1'b1;
        pulse(R_IMPLY, R_ANALYZE);
        cur_bin_num_i = 10'd2; start_core_i = 1'b1;
        @(negedge clk);
        start_core_i = 1'b0;
        check("busy_start_ignored", apply_analyze_o, 1);
        bkt_bin_num_i = 10'd5; bkt_lvl_i = 16'd3;
        pulse(R_ANALYZE, R_BKT);
        pulse(R_BKT, R_IMPLY);
        pulse(R_IMPLY, R_DECIDE);
        all_c_is_sat_i = 1'b1;
        pulse(R_DECIDE, R_DONE);
        idle_check();

        // Cross-bin UNSAT
        push_exp(5'b01000, 1'b1, 10'd2, 16'd7, 4'd1, 4'd0);
        start_solve(10'd5, 4'd0);
        conflict_i = 1'b1;
        pulse(R_IMPLY, R_ANALYZE);
        bkt_bin_num_i = 10'd2; bkt_lvl_i = 16'd7;
        pulse(R_ANALYZE, R_DONE);
        idle_check();

        // Global UNSAT
        push_exp(5'b01100, 1'b1, 10'd0, 16'd9, 4'd1, 4'd0);
        start_solve(10'd5, 4'd0);
        conflict_i = 1'b1;
        pulse(R_IMPLY, R_ANALYZE);
        bkt_bin_num_i = 10'd0; bkt_lvl_i = 16'd9;
        pulse(R_ANALYZE, R_DONE);
        idle_check();

        // Budget abort after the third decision
        push_exp(5'b00010, 1'b0, '0, '0, 4'd0, 4'd3);
        start_solve(10'd1, 4'd3);
        for (int unsigned i = 0; i < 3; i++) begin
            pulse(R_IMPLY, R_DECIDE);
            pulse(R_DECIDE, (i == 2) ? R_DONE : R_IMPLY);
        end
        idle_check();

        // Watchdog fires exactly WLIM cycles after IMPLY entry
        push_exp(5'b00011, 1'b0, '0, '0, 4'd0, 4'd0);
        start_solve(10'd1, 4'd0);
        for (int unsigned i = 1; i < WLIM; i++) begin
            @(negedge clk);
            check("wdog_imply_held", {apply_imply_o, done_core_o}, 2'b10);
        end
        @(negedge clk);
        check("wdog_done_core", done_core_o, 1);
        idle_check();

        // A done in the limit cycle beats the watchdog
        push_exp(5'b10000, 1'b0, '0, '0, 4'd0, 4'd0);
        start_solve(10'd1, 4'd0);
        repeat (WLIM - 1) @(negedge clk);
        pulse(R_IMPLY, R_DECIDE);
        all_c_is_sat_i = 1'b1;
        pulse(R_DECIDE, R_DONE);
        idle_check();

        // conflicts_o saturates at 15 with a 4-bit counter
        push_exp(5'b10000, 1'b0, '0, '0, 4'd15, 4'd0);
        start_solve(10'd4, 4'd0);
        for (int unsigned i = 0; i < 16; i++) begin
            conflict_i = 1'b1;
            pulse(R_IMPLY, R_ANALYZE);
            bkt_bin_num_i = 10'd4; bkt_lvl_i = 16'd1;
            pulse(R_ANALYZE, R_BKT);
            pulse(R_BKT, R_IMPLY);
        end
        check("conflicts_saturated", conflicts_o, 4'd15);
        pulse(R_IMPLY, R_DECIDE);
        all_c_is_sat_i = 1'b1;
        pulse(R_DECIDE, R_DONE);
        idle_check();

        // Reset in ANALYZE: everything clears, no completion pulse follows
        start_solve(10'd5, 4'd0);
        conflict_i = 1'b1;
        pulse(R_IMPLY, R_ANALYZE);
        rst = 1'b1;
        @(negedge clk);
        check("reset_in_analyze", all_outs(), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("after_reset_idle", {busy_o, done_core_o}, 2'b00);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
